multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle fetch/decode controller for the 16-bit TSC datapath. It sits directly upstream of the combinational ALU. It fetches each instruction from memory through a ready handshake and decodes it into the ALU's `aluop`, `funct`, register addresses and immediate. It sequences each instruction through IF/ID/EX/WB and issues the register write-back, output-port (WWD) strobe, PC update and halt.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_data`  in  16  instruction word returned by memory.
- `input_ready`  in  1  memory has valid `i_data` this cycle.
- `read_m`  out  1  instruction read request.
- `address`  out  16  fetch address; equals `pc`.
- `pc`  out  16  current program counter.
- `aluop`  out  4  instruction opcode field [15:12] to the ALU.
- `funct`  out  6  function field [5:0] to the ALU.
- `rs_addr`  out  2  register-file read port 1 address, field [11:10].
- `rt_addr`  out  2  register-file read port 2 address, field [9:8].
- `wr_addr`  out  2  write-back address: rd [7:6] for R-type, rt [9:8] for ADI/LHI.
- `alu_src_imm`  out  1  selects `imm_ext` instead of register data for ALU operand 2.
- `imm_ext`  out  16  extended immediate.
- `reg_write`  out  1  one-cycle register-file write strobe.
- `wwd_valid`  out  1  one-cycle strobe: the ALU `output_port` is valid.
- `num_inst`  out  16  count of completed instructions.
- `is_halted`  out  1  core has executed HLT.

## Operation
- Opcodes (fields [15:12]): RTYPE=15, ADI=4, LHI=6, JMP=9.
- R-type function codes: ADD=0, WWD=28, HLT=29.
- Any other opcode or funct executes as a NOP: no write, no strobe, PC+1, still counted.
- FSM states: IF, ID, EX, WB, HALT.
  - IF → ID when `input_ready`=1; `i_data` latches into the instruction register on that edge.
  - ID → EX → WB unconditionally.
  - WB → IF, or WB → HALT for R-type HLT.
  - HALT is absorbing until reset.
- Immediate:
  - ADI: sign-extend [7:0], `alu_src_imm`=1.
  - LHI: zero-extend [7:0], `alu_src_imm`=1.
  - All other instructions: `alu_src_imm`=0.
- Write-back (WB cycle only):
  - `reg_write`=1 for ADD, ADI, LHI.
  - `wwd_valid`=1 for WWD.
- PC update (WB edge):
  - JMP: `pc` ← {`pc`[15:12], instr[11:0]}.
  - Otherwise: `pc` ← `pc`+1, wrapping 16'hFFFF→16'h0000.
- `num_inst` increments at the WB edge of every instruction, including HLT; it wraps modulo 2^16.

## Timing
- Reset values:
  - State IF; `pc`=`RESET_PC`; `num_inst`=0.
  - Instruction register = 0.
  - `read_m`, `reg_write`, `wwd_valid`, `is_halted`, `alu_src_imm` = 0.
  - `aluop`, `funct`, address fields and `imm_ext` = 0.
- `read_m`=1 exactly while in IF, including the cycle `input_ready` is sampled high; it drops the next cycle.
- `input_ready` outside IF is ignored.
- Latency: 4 cycles per instruction with zero-wait memory; each memory wait cycle adds 1.
- Decoded outputs (`aluop`, `funct`, addresses, `imm_ext`, `alu_src_imm`) are driven from the instruction register. They are stable from ID through WB, giving the ALU two settle cycles before the write.
- `reg_write` and `wwd_valid` are registered one-cycle pulses aligned to WB, never both high.
- HALT:
  - `is_halted`=1 from the cycle after the HLT WB edge.
  - `read_m` stays 0; no further strobes.
  - `pc` holds the HLT address + 1.
- Reset asserted mid-instruction (any state) immediately clears all outputs. No partial write or strobe occurs. Fetch restarts at `RESET_PC` after deassertion.

## Structure
- Shared package/header `tsc_defs`:
  - opcode constants `OPCODE_RTYPE`, `OPCODE_ADI`, `OPCODE_LHI`, `OPCODE_JMP`;
  - funct constants `FUNC_ADD`, `FUNC_WWD`, `FUNC_HLT`;
  - state encodings.
- The ALU uses the same constants.
- One natural sub-module: `inst_decoder`, combinational. It maps the instruction register to address fields, `imm_ext`, `alu_src_imm`, write-enable class, wwd/halt/jump flags. The FSM, PC and counter stay in the top.

## Test plan
- Reset, then ADI $1,$0,-3 (16'h41FD), `input_ready` high immediately:
  - `read_m` high 1 cycle;
  - `imm_ext`=16'hFFFD, `wr_addr`=1;
  - `reg_write` pulses in cycle 4;
  - `pc`=1, `num_inst`=1.
- LHI $2,8'h5A (16'h625A) → `imm_ext`=16'h005A, `alu_src_imm`=1, `reg_write` pulse, `wr_addr`=2.
- ADD $3,$1,$2 (16'hF6C0) → `rs_addr`=1, `rt_addr`=2, `wr_addr`=3, `alu_src_imm`=0, `reg_write` pulse. Then WWD (16'hF41C) → `wwd_valid` pulse, no `reg_write`.
- `input_ready` held low 3 cycles during IF:
  - `read_m` stays high 4 cycles;
  - instruction latched only on the ready cycle;
  - total latency 7 cycles.
- JMP 12'h123 at `pc`=16'h2005 → next `address`=16'h2123. Separately, `pc`=16'hFFFF with ADI → `pc` wraps to 0.
- HLT (16'hF01D):
  - `is_halted`=1, `num_inst` incremented, `read_m` never reasserts for 10 cycles.
- Reset asserted in EX of an ADD: no `reg_write`; `pc`=`RESET_PC`; `num_inst`=0.

Source files
------------

// File: rtl/tsc_defs_pkg.sv
// Shared TSC definitions: opcode/funct constants, controller state encoding
// and the decoded-instruction bundle passed from the decoder to the controller.
package tsc_defs;

  localparam logic [3:0] OPCODE_ADI   = 4'd4;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // Which register field, if any, receives the write-back result
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_RD   = 2'd1,
    WB_RT   = 2'd2
  } wb_class_t;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [5:0]  funct;
    logic [1:0]  rs_addr;
    logic [1:0]  rt_addr;
    logic [1:0]  wr_addr;
    logic [15:0] imm_ext;
    logic        alu_src_imm;
    wb_class_t   wb_class;
    logic        is_wwd;
    logic        is_halt;
    logic        is_jump;
  } decode_t;

  function automatic logic [15:0] sign_ext8(input logic [7:0] value);
    return {{8{value[7]}}, value};
  endfunction

endpackage

// File: rtl/multicycle_control_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// ALU-facing fields and classifies write-back, output-port, halt and jump.
module inst_decoder
  import tsc_defs::*;
(
  input  logic [15:0] instr,
  output decode_t     dec
);

  always_comb begin
    dec         = '0;
    dec.aluop   = instr[15:12];
    dec.funct   = instr[5:0];
    dec.rs_addr = instr[11:10];
    dec.rt_addr = instr[9:8];

    unique case (instr[15:12])
      OPCODE_RTYPE: begin
        unique case (instr[5:0])
          FUNC_ADD: dec.wb_class = WB_RD;
          FUNC_WWD: dec.is_wwd   = 1'b1;
          FUNC_HLT: dec.is_halt  = 1'b1;
          default:  dec.wb_class = WB_NONE;
        endcase
      end
      OPCODE_ADI: begin
        dec.wb_class    = WB_RT;
        dec.imm_ext     = sign_ext8(instr[7:0]);
        dec.alu_src_imm = 1'b1;
      end
      OPCODE_LHI: begin
        dec.wb_class    = WB_RT;
        dec.imm_ext     = {8'h00, instr[7:0]};
        dec.alu_src_imm = 1'b1;
      end
      OPCODE_JMP: dec.is_jump = 1'b1;
      default:    dec.wb_class = WB_NONE;
    endcase

    // Immediate-format writes land in rt; everything else names rd
    dec.wr_addr = (dec.wb_class == WB_RT) ? instr[9:8] : instr[7:6];
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle IF/ID/EX/WB controller for the TSC datapath: fetch handshake,
// instruction register, PC/instruction counter and write-back strobes.
module multicycle_control
  import tsc_defs::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_data,
  input  logic        input_ready,
  output logic        read_m,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic [3:0]  aluop,
  output logic [5:0]  funct,
  output logic [1:0]  rs_addr,
  output logic [1:0]  rt_addr,
  output logic [1:0]  wr_addr,
  output logic        alu_src_imm,
  output logic [15:0] imm_ext,
  output logic        reg_write,
  output logic        wwd_valid,
  output logic [15:0] num_inst,
  output logic        is_halted
);

  state_t      state;
  state_t      next_state;
  logic [15:0] instr_reg;
  decode_t     dec;

  inst_decoder u_decoder (
    .instr (instr_reg),
    .dec   (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IF:   if (input_ready) next_state = ST_ID;
      ST_ID:   next_state = ST_EX;
      ST_EX:   next_state = ST_WB;
      ST_WB:   next_state = dec.is_halt ? ST_HALT : ST_IF;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_reg <= '0;
    end else if (state == ST_IF && input_ready) begin
      instr_reg <= i_data;
    end
  end

  // JMP keeps the current 4 KiB page; everything else steps and wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      num_inst <= '0;
    end else if (state == ST_WB) begin
      pc       <= dec.is_jump ? {pc[15:12], instr_reg[11:0]} : pc + 16'd1;
      num_inst <= num_inst + 16'd1;
    end
  end

  // Strobes are launched on the EX->WB edge so they are high exactly in WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write <= 1'b0;
      wwd_valid <= 1'b0;
    end else begin
      reg_write <= (state == ST_EX) && (dec.wb_class != WB_NONE);
      wwd_valid <= (state == ST_EX) && dec.is_wwd;
    end
  end

  assign read_m      = (state == ST_IF) && !reset;
  assign address     = pc;
  assign is_halted   = (state == ST_HALT);
  assign aluop       = dec.aluop;
  assign funct       = dec.funct;
  assign rs_addr     = dec.rs_addr;
  assign rt_addr     = dec.rt_addr;
  assign wr_addr     = dec.wr_addr;
  assign alu_src_imm = dec.alu_src_imm;
  assign imm_ext     = dec.imm_ext;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// predicts every output each cycle; literal checks pin key values.
module tb_multicycle_control;

  localparam logic [15:0] RST_PC = 16'hF000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_data = '0;
  logic        input_ready = 1'b0;
  logic        read_m;
  logic [15:0] address;
  logic [15:0] pc;
  logic [3:0]  aluop;
  logic [5:0]  funct;
  logic [1:0]  rs_addr;
  logic [1:0]  rt_addr;
  logic [1:0]  wr_addr;
  logic        alu_src_imm;
  logic [15:0] imm_ext;
  logic        reg_write;
  logic        wwd_valid;
  logic [15:0] num_inst;
  logic        is_halted;

  multicycle_control #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .input_ready (input_ready),
    .read_m      (read_m),
    .address     (address),
    .pc          (pc),
    .aluop       (aluop),
    .funct       (funct),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_addr     (wr_addr),
    .alu_src_imm (alu_src_imm),
    .imm_ext     (imm_ext),
    .reg_write   (reg_write),
    .wwd_valid   (wwd_valid),
    .num_inst    (num_inst),
    .is_halted   (is_halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  wr;
    logic        src;
    logic        wr_care;
    logic        imm_care;
    logic        rw;
    logic        wwd;
    logic        halt;
    logic        jmp;
  } exp_dec_t;

  // Instruction-level model state
  logic [15:0] m_pc, m_num, m_ir;
  logic        m_read, m_rw, m_wwd, m_halted;
  exp_dec_t    cd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rw_cnt = 0;
  int wwd_cnt = 0;

  function automatic exp_dec_t model_decode(input logic [15:0] w);
    exp_dec_t r;
    int op;
    int fn;
    int v;
    op = int'(w[15:12]);
    fn = int'(w[5:0]);
    r = '0;
    if (op == 4) begin
      v = int'(w[7:0]);
      if (v > 127) v = v - 256;
      r.imm = 16'(v);
      r.src = 1'b1; r.rw = 1'b1; r.wr = w[9:8];
      r.wr_care = 1'b1; r.imm_care = 1'b1;
    end else if (op == 6) begin
      r.imm = 16'(int'(w[7:0]));
      r.src = 1'b1; r.rw = 1'b1; r.wr = w[9:8];
      r.wr_care = 1'b1; r.imm_care = 1'b1;
    end else if (op == 15) begin
      r.wr = w[7:6];
      r.wr_care = 1'b1;
      r.rw = (fn == 0);
      r.wwd = (fn == 28);
      r.halt = (fn == 29);
    end else if (op == 9) begin
      r.jmp = 1'b1;
    end
    if (w == 16'h0000) begin
      r.wr_care = 1'b1;
      r.imm_care = 1'b1;
    end
    return r;
  endfunction

  task automatic check_output(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_num = '0; m_ir = '0;
    m_read = 1'b0; m_rw = 1'b0; m_wwd = 1'b0; m_halted = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    cd = model_decode(m_ir);
    if (read_m === 1'b1) rd_cnt++;
    if (reg_write === 1'b1) rw_cnt++;
    if (wwd_valid === 1'b1) wwd_cnt++;
    check_output("read_m", {15'b0, read_m}, {15'b0, m_read});
    check_output("address", address, m_pc);
    check_output("pc", pc, m_pc);
    check_output("num_inst", num_inst, m_num);
    check_output("is_halted", {15'b0, is_halted}, {15'b0, m_halted});
    check_output("reg_write", {15'b0, reg_write}, {15'b0, m_rw});
    check_output("wwd_valid", {15'b0, wwd_valid}, {15'b0, m_wwd});
    check_output("aluop", {12'b0, aluop}, {12'b0, m_ir[15:12]});
    check_output("funct", {10'b0, funct}, {10'b0, m_ir[5:0]});
    check_output("rs_addr", {14'b0, rs_addr}, {14'b0, m_ir[11:10]});
    check_output("rt_addr", {14'b0, rt_addr}, {14'b0, m_ir[9:8]});
    check_output("alu_src_imm", {15'b0, alu_src_imm}, {15'b0, cd.src});
    if (cd.wr_care) check_output("wr_addr", {14'b0, wr_addr}, {14'b0, cd.wr});
    if (cd.imm_care) check_output("imm_ext", imm_ext, cd.imm);
  end

  task automatic do_reset();
    reset = 1'b1;
    input_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_read = 1'b1;
  endtask

  // Entered just after a rising edge with the DUT in IF
  task automatic apply_stimulus(input logic [15:0] w, input int waits, input bit reset_in_ex);
    exp_dec_t d;
    d = model_decode(w);
    for (int i = 0; i < waits; i++) begin
      input_ready = 1'b0;
      i_data = 16'hF01D;
      @(posedge clk); #1;
    end
    input_ready = 1'b1;
    i_data = w;
    @(posedge clk); #1;
    input_ready = 1'b1;
    i_data = ~w;
    m_read = 1'b0;
    m_ir = w;
    @(posedge clk); #1;
    if (reset_in_ex) begin
      @(negedge clk); #1;
      reset = 1'b1;
      input_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_read = 1'b1;
      return;
    end
    @(posedge clk); #1;
    m_rw = d.rw;
    m_wwd = d.wwd;
    @(posedge clk); #1;
    input_ready = 1'b0;
    m_rw = 1'b0;
    m_wwd = 1'b0;
    m_num = m_num + 16'd1;
    m_pc = d.jmp ? {m_pc[15:12], w[11:0]} : m_pc + 16'd1;
    if (d.halt) begin
      m_halted = 1'b1;
      m_read = 1'b0;
    end else begin
      m_read = 1'b1;
    end
  endtask

  initial begin
    int c0;
    model_reset();
    do_reset();

    apply_stimulus(16'h41FD, 0, 1'b0);
    check_output("adi_imm", imm_ext, 16'hFFFD);
    check_output("adi_wr", {14'b0, wr_addr}, 16'd1);
    check_output("adi_pc", pc, 16'hF001);
    check_output("adi_num", num_inst, 16'd1);

    apply_stimulus(16'h625A, 0, 1'b0);
    check_output("lhi_imm", imm_ext, 16'h005A);
    check_output("lhi_src", {15'b0, alu_src_imm}, 16'd1);
    check_output("lhi_wr", {14'b0, wr_addr}, 16'd2);

    apply_stimulus(16'hF6C0, 0, 1'b0);
    check_output("add_rs", {14'b0, rs_addr}, 16'd1);
    check_output("add_rt", {14'b0, rt_addr}, 16'd2);
    check_output("add_wr", {14'b0, wr_addr}, 16'd3);
    check_output("add_src", {15'b0, alu_src_imm}, 16'd0);

    apply_stimulus(16'hF41C, 0, 1'b0);
    check_output("rw_pulses", 16'(rw_cnt), 16'd3);
    check_output("wwd_pulses", 16'(wwd_cnt), 16'd1);

    c0 = cyc;
    rd_cnt = 0;
    apply_stimulus(16'h4201, 3, 1'b0);
    check_output("wait_latency", 16'(cyc - c0), 16'd7);
    check_output("wait_read_cycles", 16'(rd_cnt), 16'd4);

    apply_stimulus(16'h1234, 0, 1'b0);
    apply_stimulus(16'hF005, 0, 1'b0);
    check_output("nop_pc", pc, 16'hF007);

    apply_stimulus(16'h9FFF, 0, 1'b0);
    check_output("jmp_page_pc", pc, 16'hFFFF);
    apply_stimulus(16'h4001, 0, 1'b0);
    check_output("wrap_pc", pc, 16'h0000);

    apply_stimulus(16'h9FFF, 0, 1'b0);
    for (int i = 0; i < 16'h1006; i++) apply_stimulus(16'h0000, 0, 1'b0);
    check_output("walk_pc", pc, 16'h2005);
    apply_stimulus(16'h9123, 0, 1'b0);
    check_output("jmp_addr", address, 16'h2123);
    check_output("walk_num", num_inst, 16'h1011);

    apply_stimulus(16'hF6C0, 0, 1'b1);
    check_output("rst_pc", pc, RST_PC);
    check_output("rst_num", num_inst, 16'd0);

    apply_stimulus(16'h41FD, 0, 1'b0);
    apply_stimulus(16'hF01D, 0, 1'b0);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      input_ready = 1'b1;
      i_data = 16'h41FD;
      @(posedge clk); #1;
    end
    input_ready = 1'b0;
    check_output("halt_flag", {15'b0, is_halted}, 16'd1);
    check_output("halt_pc", pc, 16'hF002);
    check_output("halt_num", num_inst, 16'd2);
    check_output("halt_reads", 16'(rd_cnt), 16'd0);

    do_reset();
    apply_stimulus(16'h625A, 0, 1'b0);
    check_output("restart_pc", pc, 16'hF001);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
